// File: rtl/afb_pkg.sv
// afb_pkg: shared FSM encoding, request/response field layout and the timeout error word.
package afb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP_HOLD = 2'd3
    } state_t;

    localparam int REQ_W       = 74;
    localparam int REQ_RD_BIT  = 72;
    localparam int REQ_IDX_HI  = 37;
    localparam int REQ_IDX_LO  = 34;
    localparam int REQ_DATA_HI = 31;
    localparam int REQ_DATA_LO = 0;

    localparam int RESP_W = 33;
    localparam logic [RESP_W-1:0] TIMEOUT_WORD = {1'b1, 32'hFFFF_FFFF};

    localparam logic [1:0] STALE_MAX = 2'd3;

endpackage

// File: rtl/afb_sync_fifo.sv
// afb_sync_fifo: synchronous FIFO with occupancy count; a push is refused whenever the
// FIFO is full, even if a pop happens in the same cycle.
module afb_sync_fifo #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [4:0]       count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && (count < DEPTH_C);
    assign do_pop  = pop && (count != 5'd0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + 5'(do_push) - 5'(do_pop);
        end
    end

endmodule

// File: rtl/afb_request_bridge.sv
// afb_request_bridge: buffers core register requests and issues them one at a time to the
// accelerator, returning responses in order and substituting an error word on timeout.
module afb_request_bridge
    import afb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AFB_ACCELERATOR_REQUEST_pipe_write_req,
    output logic              AFB_ACCELERATOR_REQUEST_pipe_write_ack,
    input  logic [REQ_W-1:0]  AFB_ACCELERATOR_REQUEST_pipe_write_data,
    input  logic              AFB_ACCELERATOR_RESPONSE_pipe_read_req,
    output logic              AFB_ACCELERATOR_RESPONSE_pipe_read_ack,
    output logic [RESP_W-1:0] AFB_ACCELERATOR_RESPONSE_pipe_read_data,
    output logic              ACC_REQUEST_pipe_write_req,
    input  logic              ACC_REQUEST_pipe_write_ack,
    output logic [REQ_W-1:0]  ACC_REQUEST_pipe_write_data,
    output logic              ACC_RESPONSE_pipe_read_req,
    input  logic              ACC_RESPONSE_pipe_read_ack,
    input  logic [RESP_W-1:0] ACC_RESPONSE_pipe_read_data,
    output logic [4:0]        fifo_count,
    output logic              timeout_flag
);
    localparam logic [4:0] DEPTH_C  = 5'(FIFO_DEPTH);
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t            state, state_n;
    logic [9:0]        timer, timer_n;
    logic [1:0]        stale, stale_n;
    logic [RESP_W-1:0] resp, resp_n;
    logic              flag_n, push, pop;

    // Ack is held off while reset is asserted so every handshake output reads 0 then.
    assign AFB_ACCELERATOR_REQUEST_pipe_write_ack = !reset && (fifo_count < DEPTH_C);
    assign push = AFB_ACCELERATOR_REQUEST_pipe_write_req && AFB_ACCELERATOR_REQUEST_pipe_write_ack;
    assign AFB_ACCELERATOR_RESPONSE_pipe_read_ack  = (state == RESP_HOLD);
    assign AFB_ACCELERATOR_RESPONSE_pipe_read_data = resp;

    afb_sync_fifo #(
        .WIDTH(REQ_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (AFB_ACCELERATOR_REQUEST_pipe_write_data),
        .dout (ACC_REQUEST_pipe_write_data),
        .count(fifo_count)
    );

    always_comb begin
        state_n = state;
        timer_n = timer;
        stale_n = stale;
        resp_n  = resp;
        flag_n  = timeout_flag;
        pop     = 1'b0;
        ACC_REQUEST_pipe_write_req = 1'b0;
        ACC_RESPONSE_pipe_read_req = 1'b0;
        case (state)
            IDLE: state_n = (fifo_count != 5'd0) ? ISSUE : IDLE;
            ISSUE: begin
                ACC_REQUEST_pipe_write_req = 1'b1;
                if (ACC_REQUEST_pipe_write_ack) begin
                    pop     = 1'b1;
                    timer_n = 10'd0;
                    state_n = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                ACC_RESPONSE_pipe_read_req = 1'b1;
                // A response while stale_cnt is nonzero belongs to a transaction already timed out.
                if (ACC_RESPONSE_pipe_read_ack && stale != 2'd0) begin
                    stale_n = stale - 2'd1;
                    timer_n = 10'd0;
                end else if (ACC_RESPONSE_pipe_read_ack) begin
                    resp_n  = ACC_RESPONSE_pipe_read_data;
                    state_n = RESP_HOLD;
                end else if (timer == TMO_LAST) begin
                    resp_n  = TIMEOUT_WORD;
                    flag_n  = 1'b1;
                    stale_n = (stale == STALE_MAX) ? STALE_MAX : stale + 2'd1;
                    state_n = RESP_HOLD;
                end else begin
                    timer_n = timer + 10'd1;
                end
            end
            RESP_HOLD: state_n = AFB_ACCELERATOR_RESPONSE_pipe_read_req ? IDLE : RESP_HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= 10'd0;
            stale        <= 2'd0;
            resp         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            stale        <= stale_n;
            resp         <= resp_n;
            timeout_flag <= flag_n;
        end
    end

endmodule
